// File: rtl/prog_mem_loader.sv
`default_nettype none
// prog_mem_loader: 128x16 program memory filled from a byte-wide host stream; holds the core in
// reset (cpu_run low) until the program is loaded.  Rev 1.0
module prog_mem_loader #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_run,
  output logic [AW:0]   load_count,
  output logic          load_err
);

  localparam int            DEPTH     = 2 ** AW;
  localparam logic [AW-1:0] LAST_ADDR = '1;
  localparam logic [AW-1:0] ONE_A     = 1;
  localparam logic [AW:0]   ONE_C     = 1;

  typedef enum logic [1:0] {
    LOAD_LO = 2'd0,
    LOAD_HI = 2'd1,
    RUN     = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr;
  logic [7:0]    lo_byte;
  logic          xfer;
  logic          wr_en;
  logic [DW-1:0] mem [0:DEPTH-1];

  // Gated by reset so the host sees "not ready" for the whole time reset is held.
  assign ld_ready = reset && ((state == LOAD_LO) || (state == LOAD_HI));
  assign xfer     = ld_valid && ld_ready;
  assign wr_en    = xfer && (state == LOAD_HI);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD_LO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD_LO: if (xfer) state_nxt = ld_last ? ERR : LOAD_HI;
      LOAD_HI: if (xfer) state_nxt = (ld_last || (wptr == LAST_ADDR)) ? RUN : LOAD_LO;
      RUN:     state_nxt = RUN;
      ERR:     state_nxt = ERR;
      default: state_nxt = LOAD_LO;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      load_count <= '0;
      lo_byte    <= '0;
      load_err   <= 1'b0;
      cpu_run    <= 1'b0;
    end else begin
      // One cycle behind RUN so the release follows the final write.
      cpu_run <= (state == RUN);
      if (xfer && (state == LOAD_LO)) begin
        lo_byte <= ld_data;
        if (ld_last) load_err <= 1'b1;
      end
      if (wr_en) begin
        wptr       <= wptr + ONE_A;
        load_count <= load_count + ONE_C;
      end
    end
  end

  // Storage is never cleared; reads past load_count are masked instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= {ld_data, lo_byte};
  end

  assign cpu_data = ({1'b0, cpu_addr} < load_count) ? mem[cpu_addr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// tb_prog_mem_loader: scoreboard bench; expected words are queued as bytes are sent and
// compared against cpu_data once the load finishes.
module tb_prog_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [6:0]  cpu_addr = 7'd0;
  logic [15:0] cpu_data;
  logic        cpu_run;
  logic [7:0]  load_count;
  logic        load_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0]  addr;
    logic [15:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] exp_mem [128];
  int          exp_count = 0;

  prog_mem_loader #(.AW(7), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_run    (cpu_run),
    .load_count (load_count),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Presents one byte from a negedge and waits (bounded) for the handshake edge.
  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = b;
    ld_last  = last;
    while (!ld_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL byte_accept: ld_ready=%b for byte %h, expected 1", ld_ready, b);
    end else begin
      @(posedge clk);
      #1;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input logic last);
    send_byte(w[7:0], 1'b0);
    send_byte(w[15:8], last);
    sb.push_back('{addr: exp_count[6:0], data: w});
    exp_mem[exp_count] = w;
    exp_count++;
  endtask

  task automatic drain_scoreboard();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cpu_addr = e.addr;
      #1;
      checks++;
      if (cpu_data !== e.data) begin
        errors++;
        $display("FAIL sb_read[%0d]: cpu_data=%h expected %h", e.addr, cpu_data, e.data);
      end
    end
  endtask

  task automatic check_count(input string name);
    checks++;
    if (load_count !== 8'(exp_count)) begin
      errors++;
      $display("FAIL %s: load_count=%0d expected %0d", name, load_count, exp_count);
    end
  endtask

  // Asserts reset between edges so any async behaviour is visible before the next clock.
  task automatic apply_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || cpu_run !== 1'b0 || load_count !== 8'd0 || load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: ready=%b run=%b count=%0d err=%b expected 0 0 0 0",
               ld_ready, cpu_run, load_count, load_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_count = 0;
    sb.delete();
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (ld_ready !== 1'b1 || cpu_run !== 1'b0 || load_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b run=%b count=%0d expected 1 0 0",
               ld_ready, cpu_run, load_count);
    end
  endtask

  task automatic load_two_words(input string name);
    send_word(16'h1234, 1'b0);
    send_word(16'h5678, 1'b1);
    checks++;
    if (cpu_run !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_run_early: run=%b ready=%b expected 0 0", name, cpu_run, ld_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL %s_run: cpu_run=%b expected 1", name, cpu_run);
    end
    check_count(name);
    drain_scoreboard();
    cpu_addr = 7'd2;
    #1;
    checks++;
    if (cpu_data !== 16'h0000) begin
      errors++;
      $display("FAIL %s_unloaded: cpu_data=%h expected 0000", name, cpu_data);
    end
  endtask

  task automatic test_basic_load();
    load_two_words("basic");
  endtask

  task automatic test_odd_count();
    apply_reset();
    send_word(16'hBBAA, 1'b0);
    send_byte(8'hCC, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (load_err !== 1'b1 || ld_ready !== 1'b0 || cpu_run !== 1'b0) begin
      errors++;
      $display("FAIL odd_count: err=%b ready=%b run=%b expected 1 0 0", load_err, ld_ready, cpu_run);
    end
    check_count("odd_count");
    drain_scoreboard();
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 128; i++) send_word(16'($urandom), 1'b0);
    checks++;
    if (ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: ld_ready=%b expected 0", ld_ready);
    end
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL full_byte257: ld_ready=%b expected 0", ld_ready);
      end
    end
    ld_valid = 1'b0;
    checks++;
    if (cpu_run !== 1'b1) begin
      errors++;
      $display("FAIL full_run: cpu_run=%b expected 1", cpu_run);
    end
    check_count("full_count");
    cpu_addr = 7'd127;
    #1;
    checks++;
    if (cpu_data !== exp_mem[127]) begin
      errors++;
      $display("FAIL full_last_word: cpu_data=%h expected %h", cpu_data, exp_mem[127]);
    end
    drain_scoreboard();
  endtask

  task automatic test_throttle();
    apply_reset();
    send_byte(8'hEF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_count("throttle_gap");
    send_byte(8'hBE, 1'b0);
    sb.push_back('{addr: 7'd0, data: 16'hBEEF});
    exp_mem[0] = 16'hBEEF;
    exp_count = 1;
    repeat (3) @(posedge clk);
    #1;
    check_count("throttle_single");
    send_word(16'hCAFE, 1'b1);
    check_count("throttle_second");
    drain_scoreboard();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 3; i++) send_word(16'hA000 + 16'(i), 1'b0);
    send_byte(8'h77, 1'b0);
    sb.delete();
    apply_reset();
    for (int a = 0; a < 128; a++) begin
      cpu_addr = 7'(a);
      #1;
      checks++;
      if (cpu_data !== 16'h0000) begin
        errors++;
        $display("FAIL mid_reset_zero[%0d]: cpu_data=%h expected 0000", a, cpu_data);
      end
    end
    load_two_words("reload");
  endtask

  task automatic test_run_ignore();
    @(negedge clk);
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL run_ignore_ready: ld_ready=%b expected 0", ld_ready);
      end
    end
    ld_valid = 1'b0;
    check_count("run_ignore_count");
    for (int a = 0; a < exp_count; a++) sb.push_back('{addr: 7'(a), data: exp_mem[a]});
    drain_scoreboard();
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_odd_count();
    test_full();
    test_throttle();
    test_reset_mid();
    test_run_ignore();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
